multicycle_sequencer: RTL and testbench
=======================================

// Module: multicycle_sequencer
// PURPOSE
//  Multi-cycle FSM that sequences the LEGv8 datapath: fetch -> decode -> execute -> memory -> writeback.
//  Owns the PC, strobes the instruction register, register file, ALU and data memory, and decides the next PC.
//  Sits between instruction_memory/decoder and the register file, ALU and data memory.
//  Replaces the single-cycle Control path when memories respond over a req/ack handshake.
// PARAMETERS
//  PC_W       32  PC / instruction address width
//  RESET_PC   0   PC value loaded at reset
// PORTS
//  clk           in   1   rising-edge clock, single domain
//  rst_n         in   1   asynchronous, active-low reset
//  opcode        in   11  decoder opcode field of latched instruction
//  cond_br_addr  in   19  CBZ offset in words (signed)
//  br_addr       in   26  B offset in words (signed)
//  alu_zero      in   1   ALU zero flag, valid in EXECUTE
//  imem_ack      in   1   instruction memory done; data valid this cycle
//  dmem_ack      in   1   data memory done
//  pc            out  PC_W current instruction address
//  imem_req      out  1   instruction fetch request
//  ir_we         out  1   latch instruction register
//  reg2loc/alu_src/mem_to_reg  out 1 each  datapath muxes (LEGv8 Control meaning)
//  alu_op        out  2   00 add (LD/ST), 01 pass-B/zero test (CBZ), 10 R-type funct
//  reg_we        out  1   register file write strobe (one cycle)
//  dmem_req/dmem_we  out 1 each  data memory request / write qualifier
//  state_o       out  3   current FSM state, debug
//  illegal       out  1   sticky: undecodable opcode seen
// BEHAVIOUR
//  Reset (async, rst_n=0): state=FETCH, pc=RESET_PC, illegal=0; all strobes/reqs 0, muxes 0, alu_op=00.
//  States: FETCH(0) DECODE(1) EXEC(2) MEM(3) WB(4) HALT(5).
//  FETCH: imem_req=1 held until imem_ack; on ack ir_we=1 same cycle, -> DECODE. No ack = wait forever.
//  DECODE: classify opcode (registered class): R = ADD 10001011000, SUB 11001011000, AND 10001010000,
//   ORR 10101010000; LDUR 11111000010; STUR 11111000000; CBZ opcode[10:3]=10110100; B opcode[10:5]=000101.
//   Any other -> illegal<=1, -> HALT. Else -> EXEC.
//  EXEC: drive muxes/alu_op for class. B: pc<=pc+(sext(br_addr)<<2), -> FETCH.
//   CBZ: reg2loc=1; pc<=alu_zero ? pc+(sext(cond_br_addr)<<2) : pc+4; -> FETCH.
//   R -> WB. LDUR/STUR (alu_src=1) -> MEM.
//  MEM: dmem_req=1 (dmem_we=1 for STUR) held until dmem_ack. LDUR -> WB; STUR: pc<=pc+4, -> FETCH.
//  WB: reg_we=1 one cycle, mem_to_reg=1 for LDUR; pc<=pc+4; -> FETCH.
//  HALT: terminal; all reqs/strobes 0; leave only via rst_n.
//  Latency (zero-wait memories, ack in first req cycle): B/CBZ 3, STUR 4, R 4, LDUR 5 cycles.
//  Mux outputs held stable EXEC through WB of the same instruction.
//  PC arithmetic mod 2^PC_W: wrap silent, no flag. Offsets sign-extended to PC_W before shift.
//  ack while corresponding req=0: ignored. Reset mid-handshake: req drops async; stale ack after reset ignored.
// CONFIGURATION
//  PERF_COUNT_EN defined: adds cycle_cnt[63:0] (+1 every cycle not in HALT) and instret[63:0]
//   (+1 on each EXEC/MEM/WB exit to FETCH); both reset to 0, wrap.
//  Not defined: ports and counters absent; all else identical.
// STRUCTURE
//  Shared package legv8_pkg: opcode constants, state encoding, instr-class enum, alu_op codes.
//  One sub-module: legv8_opclass (combinational opcode -> class + illegal); FSM and PC stay here.
// TESTING
//  ADD at pc=0, ack in first req cycle -> states 0,1,2,4; reg_we 1 cycle in WB; pc=4 after.
//  LDUR, dmem_ack delayed 3 cycles -> dmem_req high exactly 4 cycles, dmem_we=0, mem_to_reg=1 in WB, pc=4.
//  CBZ offset -2 at pc=0x10: alu_zero=1 -> pc=0x08; alu_zero=0 -> pc=0x14; reg_we never 1.
//  B br_addr=0x3FFFFFF at pc=0 -> pc=0xFFFFFFFC (wrap); STUR -> dmem_we=1, no reg_we.
//  opcode 0 -> illegal=1, state HALT, no further imem_req; rst_n low -> illegal=0, pc=RESET_PC.
//  rst_n low during FETCH wait -> imem_req 0 same cycle; ack after release ignored until req raised.

Source files
------------

// File: rtl/legv8_pkg.sv
// Shared LEGv8 sequencer definitions: state encoding, opcode constants,
// instruction classes and ALU operation codes.
package legv8_pkg;

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [7:0]  OP_CBZ_HI = 8'b10110100;
    localparam logic [5:0]  OP_B_HI   = 6'b000101;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_PASSB = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    typedef enum logic [2:0] {
        CL_NONE = 3'd0,
        CL_R    = 3'd1,
        CL_LD   = 3'd2,
        CL_ST   = 3'd3,
        CL_CBZ  = 3'd4,
        CL_B    = 3'd5
    } iclass_e;

endpackage

// File: rtl/legv8_opclass.sv
// Combinational LEGv8 opcode classifier.
// Ports: i_opcode (11b) in; o_class (instruction class), o_illegal out.
module legv8_opclass
    import legv8_pkg::*;
(
    input  logic [10:0] i_opcode,
    output iclass_e     o_class,
    output logic        o_illegal
);

    always_comb begin
        o_class   = CL_NONE;
        o_illegal = 1'b0;
        unique case (1'b1)
            (i_opcode == OP_ADD),
            (i_opcode == OP_SUB),
            (i_opcode == OP_AND),
            (i_opcode == OP_ORR):          o_class = CL_R;
            (i_opcode == OP_LDUR):         o_class = CL_LD;
            (i_opcode == OP_STUR):         o_class = CL_ST;
            (i_opcode[10:3] == OP_CBZ_HI): o_class = CL_CBZ;
            (i_opcode[10:5] == OP_B_HI):   o_class = CL_B;
            default:                       o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle LEGv8 control FSM: fetch/decode/exec/mem/wb, owns the PC.
// Ports: clk, rst_n (async low); opcode, cond_br_addr, br_addr, alu_zero,
//  imem_ack, dmem_ack in; pc, imem_req, ir_we, reg2loc, alu_src,
//  mem_to_reg, alu_op, reg_we, dmem_req, dmem_we, state_o, illegal out.
// Macro PERF_COUNT_EN adds cycle_cnt and instret outputs.
module multicycle_sequencer
    import legv8_pkg::*;
#(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [10:0]     opcode,
    input  logic [18:0]     cond_br_addr,
    input  logic [25:0]     br_addr,
    input  logic            alu_zero,
    input  logic            imem_ack,
    input  logic            dmem_ack,
    output logic [PC_W-1:0] pc,
    output logic            imem_req,
    output logic            ir_we,
    output logic            reg2loc,
    output logic            alu_src,
    output logic            mem_to_reg,
    output logic [1:0]      alu_op,
    output logic            reg_we,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [2:0]      state_o,
    output logic            illegal
`ifdef PERF_COUNT_EN
    ,
    output logic [63:0]     cycle_cnt,
    output logic [63:0]     instret
`endif
);

    logic [2:0]      r_state;
    logic [2:0]      w_state_nxt;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_pc_nxt;
    logic [PC_W-1:0] w_pc_seq;
    logic [PC_W-1:0] w_br_tgt;
    logic [PC_W-1:0] w_cbz_tgt;
    iclass_e         r_cls;
    iclass_e         w_cls;
    logic            r_illegal;
    logic            w_illegal;
    logic            w_dp;

    legv8_opclass u_opclass (
        .i_opcode  (opcode),
        .o_class   (w_cls),
        .o_illegal (w_illegal)
    );

    assign w_pc_seq  = r_pc + PC_W'(4);
    assign w_br_tgt  = r_pc +
        ({{(PC_W-26){br_addr[25]}}, br_addr} << 2);
    assign w_cbz_tgt = r_pc +
        ({{(PC_W-19){cond_br_addr[18]}}, cond_br_addr} << 2);

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        case (r_state)
            S_FETCH: begin
                if (imem_ack) w_state_nxt = S_DECODE;
            end
            S_DECODE: begin
                w_state_nxt = w_illegal ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                case (r_cls)
                    CL_B: begin
                        w_pc_nxt    = w_br_tgt;
                        w_state_nxt = S_FETCH;
                    end
                    CL_CBZ: begin
                        w_pc_nxt    = alu_zero ? w_cbz_tgt : w_pc_seq;
                        w_state_nxt = S_FETCH;
                    end
                    CL_R:         w_state_nxt = S_WB;
                    CL_LD, CL_ST: w_state_nxt = S_MEM;
                    default:      w_state_nxt = S_HALT;
                endcase
            end
            S_MEM: begin
                if (dmem_ack) begin
                    if (r_cls == CL_ST) begin
                        w_pc_nxt    = w_pc_seq;
                        w_state_nxt = S_FETCH;
                    end else begin
                        w_state_nxt = S_WB;
                    end
                end
            end
            S_WB: begin
                w_pc_nxt    = w_pc_seq;
                w_state_nxt = S_FETCH;
            end
            S_HALT:  w_state_nxt = S_HALT;
            default: w_state_nxt = S_HALT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_FETCH;
            r_pc      <= RESET_PC;
            r_cls     <= CL_NONE;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            if (r_state == S_DECODE) begin
                r_cls <= w_cls;
                if (w_illegal) r_illegal <= 1'b1;
            end
        end
    end

    // Requests are gated by rst_n so they drop the moment reset asserts,
    // not at the next edge; a stale ack cannot then complete a handshake.
    assign imem_req = rst_n && (r_state == S_FETCH);
    assign dmem_req = rst_n && (r_state == S_MEM);
    assign ir_we    = imem_req && imem_ack;
    assign dmem_we  = dmem_req && (r_cls == CL_ST);
    assign reg_we   = (r_state == S_WB);

    // Muxes follow the latched class for EXEC..WB so they stay stable
    // across the whole data phase of one instruction.
    assign w_dp = (r_state == S_EXEC) || (r_state == S_MEM) ||
                  (r_state == S_WB);

    assign reg2loc    = w_dp && ((r_cls == CL_CBZ) || (r_cls == CL_ST));
    assign alu_src    = w_dp && ((r_cls == CL_LD) || (r_cls == CL_ST));
    assign mem_to_reg = w_dp && (r_cls == CL_LD);

    always_comb begin
        alu_op = ALUOP_ADD;
        if (w_dp && (r_cls == CL_CBZ)) alu_op = ALUOP_PASSB;
        else if (w_dp && (r_cls == CL_R)) alu_op = ALUOP_RTYPE;
    end

    assign pc      = r_pc;
    assign state_o = r_state;
    assign illegal = r_illegal;

`ifdef PERF_COUNT_EN
    logic w_retire;

    assign w_retire = w_dp && (w_state_nxt == S_FETCH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt <= '0;
            instret   <= '0;
        end else begin
            if (r_state != S_HALT) cycle_cnt <= cycle_cnt + 64'd1;
            if (w_retire)          instret   <= instret + 64'd1;
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Scoreboard bench for multicycle_sequencer: random LEGv8 instruction
// stream with random memory wait states, checked against a reference model.
`timescale 1ns/1ps
module tb_multicycle_sequencer;

    localparam int R = 0, LD = 1, ST = 2, CBZ = 3, BR = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] opcode = '0;
    logic [18:0] cond_br_addr = '0;
    logic [25:0] br_addr = '0;
    logic        alu_zero = 1'b0;
    logic        imem_ack = 1'b0;
    logic        dmem_ack = 1'b0;
    logic [31:0] pc;
    logic        imem_req, ir_we, reg2loc, alu_src, mem_to_reg;
    logic [1:0]  alu_op;
    logic        reg_we, dmem_req, dmem_we, illegal;
    logic [2:0]  state_o;
`ifdef PERF_COUNT_EN
    logic [63:0] cycle_cnt, instret;
`endif

    multicycle_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .opcode       (opcode),
        .cond_br_addr (cond_br_addr),
        .br_addr      (br_addr),
        .alu_zero     (alu_zero),
        .imem_ack     (imem_ack),
        .dmem_ack     (dmem_ack),
        .pc           (pc),
        .imem_req     (imem_req),
        .ir_we        (ir_we),
        .reg2loc      (reg2loc),
        .alu_src      (alu_src),
        .mem_to_reg   (mem_to_reg),
        .alu_op       (alu_op),
        .reg_we       (reg_we),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .state_o      (state_o),
        .illegal      (illegal)
`ifdef PERF_COUNT_EN
        ,
        .cycle_cnt    (cycle_cnt),
        .instret      (instret)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic [31:0] fpc;
        logic [31:0] npc;
        int          cyc;
        int          rw;
        int          dcyc;
        bit          dwe;
        bit          m2r;
        bit          chkmux;
        logic [1:0]  aop;
        bit          asrc;
        bit          r2l;
    } exp_t;

    typedef struct {
        int          cls;
        logic [10:0] op;
        logic [25:0] br;
        logic [18:0] cbr;
        bit          z;
        int          iw;
        int          dw;
    } ins_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_pc = '0;
    int          cur_dw = 0;
    int          n_issued = 0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    // data memory responder: ack after cur_dw wait cycles
    int dcnt = 0;
    always @(negedge clk) begin
        if (dmem_req === 1'b1) begin
            dmem_ack = (dcnt == cur_dw);
            dcnt++;
        end else begin
            dmem_ack = 1'b0;
            dcnt = 0;
        end
    end

    // monitor: one record per instruction, closed when FETCH is re-entered
    logic [2:0]  prev = 3'd7;
    bit          started = 0;
    int          cyc, rw, dcyc;
    bit          dwe, m2r, unstable, mux_seen;
    logic [31:0] fpc;
    logic [3:0]  mux_ex, mux_cur;
    exp_t        e;
    always @(negedge clk) begin
        if (rst_n !== 1'b1) begin
            prev = 3'd7;
            started = 0;
        end else begin
            if (state_o == 3'd0 && prev != 3'd0) begin
                if (started) begin
                    if (sb.size() == 0) begin
                        chk("sb_underflow", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        chk($sformatf("i%0d fetch_pc", e.idx), fpc, e.fpc);
                        chk($sformatf("i%0d next_pc", e.idx), pc, e.npc);
                        chk($sformatf("i%0d cycles", e.idx), cyc, e.cyc);
                        chk($sformatf("i%0d reg_we_n", e.idx), rw, e.rw);
                        chk($sformatf("i%0d dmem_req_n", e.idx), dcyc, e.dcyc);
                        chk($sformatf("i%0d dmem_we", e.idx), dwe, e.dwe);
                        chk($sformatf("i%0d mem_to_reg", e.idx), m2r, e.m2r);
                        chk($sformatf("i%0d mux_stable", e.idx), unstable, 0);
                        if (e.chkmux)
                            chk($sformatf("i%0d muxes", e.idx), mux_ex,
                                {e.aop, e.asrc, e.r2l});
                    end
                end
                started = 1;
                cyc = 0; rw = 0; dcyc = 0;
                dwe = 0; m2r = 0; unstable = 0; mux_seen = 0;
                fpc = pc;
            end
            if (started) begin
                cyc++;
                if (reg_we) begin
                    rw++;
                    m2r = mem_to_reg;
                end
                if (dmem_req) dcyc++;
                if (dmem_we) dwe = 1;
                if (state_o inside {3'd2, 3'd3, 3'd4}) begin
                    mux_cur = {alu_op, alu_src, reg2loc};
                    if (!mux_seen) begin
                        mux_ex = mux_cur;
                        mux_seen = 1;
                    end else if (mux_cur != mux_ex) begin
                        unstable = 1;
                    end
                end
            end
            prev = state_o;
        end
    end

    function automatic ins_t mk(int cls, logic [10:0] op, logic [25:0] br,
                                logic [18:0] cbr, bit z, int iw, int dw);
        ins_t t;
        t.cls = cls; t.op = op; t.br = br; t.cbr = cbr;
        t.z = z; t.iw = iw; t.dw = dw;
        return t;
    endfunction

    // driver + reference model: compute expectations from the ISA rules
    task automatic issue(ins_t in, bit align);
        exp_t   x;
        int     n = 0;
        longint off;
        if (align) @(negedge clk);
        while (imem_req !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (imem_req !== 1'b1) begin
            chk("imem_req_timeout", 0, 1);
            return;
        end
        opcode = in.op; br_addr = in.br; cond_br_addr = in.cbr;
        alu_zero = in.z; cur_dw = in.dw;
        x.idx = n_issued++;
        x.fpc = m_pc;
        x.npc = m_pc + 32'd4;
        x.rw = 0; x.dcyc = 0; x.dwe = 0; x.m2r = 0;
        x.chkmux = 1; x.aop = 2'd0; x.asrc = 0; x.r2l = 0;
        case (in.cls)
            R: begin
                x.cyc = in.iw + 4; x.rw = 1; x.aop = 2'd2;
            end
            LD: begin
                x.cyc = in.iw + in.dw + 5; x.rw = 1; x.dcyc = in.dw + 1;
                x.m2r = 1; x.asrc = 1;
            end
            ST: begin
                x.cyc = in.iw + in.dw + 4; x.dcyc = in.dw + 1;
                x.dwe = 1; x.asrc = 1; x.r2l = 1;
            end
            CBZ: begin
                off = longint'($signed(in.cbr));
                if (in.z) x.npc = m_pc + 32'(off * 4);
                x.cyc = in.iw + 3; x.aop = 2'd1; x.r2l = 1;
            end
            default: begin
                off = longint'($signed(in.br));
                x.npc = m_pc + 32'(off * 4);
                x.cyc = in.iw + 3; x.chkmux = 0;
            end
        endcase
        m_pc = x.npc;
        sb.push_back(x);
        repeat (in.iw) @(negedge clk);
        imem_ack = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
    endtask

    task automatic wait_empty();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("sb_drain", sb.size(), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst pc", pc, 0);
        chk("rst state", state_o, 0);
        chk("rst illegal", illegal, 0);
        chk("rst strobes", {imem_req, ir_we, reg_we, dmem_req, dmem_we}, 0);
        chk("rst muxes", {reg2loc, alu_src, mem_to_reg, alu_op}, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_pc = '0;
    endtask

    logic [10:0] rops [4];
    initial begin
        ins_t t;
        int   cls, hb;
        rops[0] = 11'b10001011000;
        rops[1] = 11'b11001011000;
        rops[2] = 11'b10001010000;
        rops[3] = 11'b10101010000;

        do_reset();
        // directed walk: ADD, LDUR slow dmem, B, CBZ taken/not taken, STUR
        issue(mk(R, rops[0], 0, 0, 0, 0, 0), 1);
        issue(mk(LD, 11'b11111000010, 0, 0, 0, 0, 3), 1);
        issue(mk(BR, 11'b00010100000, 26'd2, 0, 0, 0, 0), 1);
        issue(mk(CBZ, 11'b10110100000, 0, 19'h7FFFE, 1, 0, 0), 1);
        issue(mk(BR, 11'b00010100000, 26'd2, 0, 0, 1, 0), 1);
        issue(mk(CBZ, 11'b10110100000, 0, 19'h7FFFE, 0, 0, 0), 1);
        issue(mk(ST, 11'b11111000000, 0, 0, 0, 1, 0), 1);
        issue(mk(R, rops[3], 0, 0, 0, 2, 0), 1);
        wait_empty();

        do_reset();
        // backward branch from pc 0 wraps to the top of the space
        issue(mk(BR, 11'b00010111111, 26'h3FFFFFF, 0, 0, 0, 0), 1);
        for (int i = 0; i < 150; i++) begin
            cls = int'($urandom_range(0, 4));
            t = mk(cls, rops[$urandom_range(0, 3)],
                   26'($signed(int'($urandom_range(0, 63)) - 32)),
                   19'($signed(int'($urandom_range(0, 63)) - 32)),
                   bit'($urandom_range(0, 1)),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            if (cls == LD) t.op = 11'b11111000010;
            if (cls == ST) t.op = 11'b11111000000;
            if (cls == CBZ) t.op = {8'b10110100, 3'($urandom)};
            if (cls == BR) t.op = {6'b000101, 5'($urandom)};
            issue(t, 1);
        end
        wait_empty();

        // undecodable opcode halts the sequencer
        @(negedge clk);
        hb = 0;
        while (imem_req !== 1'b1 && hb < 100) begin
            @(negedge clk);
            hb++;
        end
        opcode = 11'd0;
        imem_ack = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
        repeat (2) @(negedge clk);
        chk("halt state", state_o, 5);
        chk("halt illegal", illegal, 1);
        hb = 0;
        for (int i = 0; i < 6; i++) begin
            imem_ack = i[0];
            dmem_ack = i[0];
            @(negedge clk);
            if (imem_req || ir_we || reg_we || dmem_req || dmem_we) hb++;
        end
        imem_ack = 1'b0;
        chk("halt quiet", hb, 0);
        chk("halt stays", state_o, 5);

        do_reset();
        // reset in the middle of an unanswered fetch
        @(negedge clk);
        chk("fetch wait req", imem_req, 1);
        @(negedge clk);
        chk("fetch wait state", state_o, 0);
        rst_n = 1'b0;
        #1;
        chk("midfetch req", imem_req, 0);
        imem_ack = 1'b1;
        #1;
        chk("stale ack ir_we", ir_we, 0);
        @(posedge clk);
        #1;
        chk("stale ack state", state_o, 0);
        imem_ack = 1'b0;
        rst_n = 1'b1;
        m_pc = '0;
        @(negedge clk);
        chk("post rst req", imem_req, 1);
        chk("post rst pc", pc, 0);
        issue(mk(R, rops[1], 0, 0, 0, 0, 0), 0);
        wait_empty();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
